// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: opcodes, funct3 encodings, ALU ops, FSM states.
package rv32_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000, F3_SLL = 3'b001, F3_SLT = 3'b010, F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100, F3_SR  = 3'b101, F3_OR  = 3'b110, F3_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ  = 3'b000, F3_BNE = 3'b001, F3_BLT = 3'b100, F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110, F3_BGEU = 3'b111;
  localparam logic [2:0] F3_LB   = 3'b000, F3_LH  = 3'b001, F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU  = 3'b100, F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB   = 3'b000, F3_SH  = 3'b001, F3_SW  = 3'b010;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_MEM} state_t;

  function automatic logic [31:0] alu_exec(input alu_op_t op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    case (op)
      ALU_SUB:  r = a - b;
      ALU_SLL:  r = a << b[4:0];
      ALU_SLT:  r = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: r = {31'b0, a < b};
      ALU_XOR:  r = a ^ b;
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA:  r = $signed(a) >>> b[4:0];
      ALU_OR:   r = a | b;
      ALU_AND:  r = a & b;
      default:  r = a + b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rv32_bram.sv
// Dual-port byte-enabled RAM, synchronous read-first; port 2 wins byte collisions.
module rv32_bram #(
  parameter int unsigned BRAM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a1,
  input  logic [31:0] wd1,
  input  logic [3:0]  we1,
  output logic [31:0] rd1,
  input  logic [31:0] a2,
  input  logic [31:0] wd2,
  input  logic [3:0]  we2,
  output logic [31:0] rd2
);
  localparam int unsigned AW = $clog2(BRAM_WORDS);

  logic [31:0]   mem [BRAM_WORDS];
  logic [AW-1:0] i1, i2;
  logic          unused_addr;

  assign i1 = a1[AW+1:2];
  assign i2 = a2[AW+1:2];
  assign unused_addr = ^{a1[31:AW+2], a1[1:0], a2[31:AW+2], a2[1:0]};

  // Storage and port-1 read; port 2 written last so it overrides a same-byte port-1 write
  always_ff @(posedge clk) begin
    rd1 <= mem[i1];
    for (int unsigned b = 0; b < 4; b++) begin
      if (we1[b]) mem[i1][8*b +: 8] <= wd1[8*b +: 8];
      if (we2[b]) mem[i2][8*b +: 8] <= wd2[8*b +: 8];
    end
  end

  // Debug read register, cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd2 <= '0;
    else     rd2 <= mem[i2];
  end
endmodule

// File: rtl/rv32_core.sv
// Multi-cycle RV32I core (FETCH/DECODE/MEM) with private instruction and data BRAMs.
module rv32_core
  import rv32_pkg::*;
#(
  parameter int unsigned BRAM_WORDS = 4096
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST,
  input  logic [31:0] CPU_Debug_DataRAM_A2,
  input  logic [31:0] CPU_Debug_DataRAM_WD2,
  input  logic [3:0]  CPU_Debug_DataRAM_WE2,
  output logic [31:0] CPU_Debug_DataRAM_RD2,
  input  logic [31:0] CPU_Debug_InstRAM_A2,
  input  logic [31:0] CPU_Debug_InstRAM_WD2,
  input  logic [3:0]  CPU_Debug_InstRAM_WE2,
  output logic [31:0] CPU_Debug_InstRAM_RD2
);
  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] rf [32];
  logic [31:0] inst, dmem_rd, dmem_addr, dmem_wd;
  logic [3:0]  dmem_we;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [2:0]  ld_f3;
  logic [1:0]  ld_off;
  logic [4:0]  ld_rd;

  rv32_bram #(.BRAM_WORDS(BRAM_WORDS)) u_imem (
    .clk(CPU_CLK), .rst(CPU_RST),
    .a1(pc), .wd1('0), .we1('0), .rd1(inst),
    .a2(CPU_Debug_InstRAM_A2), .wd2(CPU_Debug_InstRAM_WD2),
    .we2(CPU_Debug_InstRAM_WE2), .rd2(CPU_Debug_InstRAM_RD2)
  );

  rv32_bram #(.BRAM_WORDS(BRAM_WORDS)) u_dmem (
    .clk(CPU_CLK), .rst(CPU_RST),
    .a1(dmem_addr), .wd1(dmem_wd), .we1(dmem_we), .rd1(dmem_rd),
    .a2(CPU_Debug_DataRAM_A2), .wd2(CPU_Debug_DataRAM_WD2),
    .we2(CPU_Debug_DataRAM_WE2), .rd2(CPU_Debug_DataRAM_RD2)
  );

  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1v, rs2v, alu_b, alu_res, ld_addr, st_addr, ld_val;
  alu_op_t     alu_op;
  logic        alu_ok, br_taken, load_ok;

  assign opcode  = inst[6:0];
  assign rd      = inst[11:7];
  assign f3      = inst[14:12];
  assign rs1     = inst[19:15];
  assign rs2     = inst[24:20];
  assign f7      = inst[31:25];
  assign imm_i   = {{20{inst[31]}}, inst[31:20]};
  assign imm_s   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u   = {inst[31:12], 12'b0};
  assign imm_j   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign rs1v    = rf[rs1];
  assign rs2v    = rf[rs2];
  assign alu_b   = (opcode == OP) ? rs2v : imm_i;
  assign alu_res = alu_exec(alu_op, rs1v, alu_b);
  assign ld_addr = rs1v + imm_i;
  assign st_addr = rs1v + imm_s;
  assign load_ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                   (f3 == F3_LBU) || (f3 == F3_LHU);

  // ALU operation select and funct7 legality for OP / OP_IMM
  always_comb begin
    alu_op = ALU_ADD;
    alu_ok = 1'b1;
    case (f3)
      F3_ADD:  alu_op = (opcode == OP && inst[30]) ? ALU_SUB : ALU_ADD;
      F3_SLL:  alu_op = ALU_SLL;
      F3_SLT:  alu_op = ALU_SLT;
      F3_SLTU: alu_op = ALU_SLTU;
      F3_XOR:  alu_op = ALU_XOR;
      F3_SR:   alu_op = inst[30] ? ALU_SRA : ALU_SRL;
      F3_OR:   alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
    if (opcode == OP)
      alu_ok = (f7 == 7'b0) || (f7 == 7'b0100000 && (f3 == F3_ADD || f3 == F3_SR));
    else if (f3 == F3_SLL)
      alu_ok = (f7 == 7'b0);
    else if (f3 == F3_SR)
      alu_ok = (f7 == 7'b0) || (f7 == 7'b0100000);
  end

  // Branch condition
  always_comb begin
    case (f3)
      F3_BEQ:  br_taken = (rs1v == rs2v);
      F3_BNE:  br_taken = (rs1v != rs2v);
      F3_BLT:  br_taken = ($signed(rs1v) < $signed(rs2v));
      F3_BGE:  br_taken = ($signed(rs1v) >= $signed(rs2v));
      F3_BLTU: br_taken = (rs1v < rs2v);
      F3_BGEU: br_taken = (rs1v >= rs2v);
      default: br_taken = 1'b0;
    endcase
  end

  // Load data lane extraction using the offset captured in DECODE
  always_comb begin
    logic [7:0]  lb;
    logic [15:0] lh;
    lb = dmem_rd[8*ld_off +: 8];
    lh = ld_off[1] ? dmem_rd[31:16] : dmem_rd[15:0];
    case (ld_f3)
      F3_LB:   ld_val = {{24{lb[7]}}, lb};
      F3_LH:   ld_val = {{16{lh[15]}}, lh};
      F3_LBU:  ld_val = {24'b0, lb};
      F3_LHU:  ld_val = {16'b0, lh};
      default: ld_val = dmem_rd;
    endcase
  end

  // Next state, PC, register write-back and store strobes
  always_comb begin
    state_next = S_FETCH;
    pc_next    = pc;
    rf_we      = 1'b0;
    rf_wa      = rd;
    rf_wd      = '0;
    dmem_addr  = ld_addr;
    dmem_wd    = '0;
    dmem_we    = '0;
    case (state)
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        pc_next = pc + 32'd4;
        case (opcode)
          OP, OP_IMM: begin rf_we = alu_ok; rf_wd = alu_res; end
          LUI:        begin rf_we = 1'b1; rf_wd = imm_u; end
          AUIPC:      begin rf_we = 1'b1; rf_wd = pc + imm_u; end
          JAL: begin
            rf_we   = 1'b1;
            rf_wd   = pc + 32'd4;
            pc_next = (pc + imm_j) & ~32'h3;
          end
          JALR: if (f3 == 3'b000) begin
            rf_we   = 1'b1;
            rf_wd   = pc + 32'd4;
            pc_next = (rs1v + imm_i) & ~32'h3;
          end
          BRANCH: if (br_taken) pc_next = (pc + imm_b) & ~32'h3;
          LOAD: if (load_ok) begin
            pc_next    = pc;
            state_next = S_MEM;
          end
          STORE: begin
            dmem_addr = st_addr;
            case (f3)
              F3_SB: begin dmem_we = 4'b0001 << st_addr[1:0]; dmem_wd = {4{rs2v[7:0]}}; end
              F3_SH: begin dmem_we = st_addr[1] ? 4'b1100 : 4'b0011; dmem_wd = {2{rs2v[15:0]}}; end
              F3_SW: begin dmem_we = 4'b1111; dmem_wd = rs2v; end
              default: ;
            endcase
          end
          default: ;
        endcase
      end
      S_MEM: begin
        rf_we   = 1'b1;
        rf_wa   = ld_rd;
        rf_wd   = ld_val;
        pc_next = pc + 32'd4;
      end
      default: state_next = S_FETCH;
    endcase
    // A store whose edge coincides with reset assertion must not land
    if (CPU_RST) dmem_we = '0;
  end

  // FSM state register
  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) state <= S_FETCH;
    else         state <= state_next;
  end

  // PC and register file; x0 is never written so it always reads 0
  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      pc <= '0;
      for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      pc <= pc_next;
      if (rf_we && rf_wa != 5'd0) rf[rf_wa] <= rf_wd;
    end
  end

  // Load context held for the MEM cycle
  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      ld_f3  <= '0;
      ld_off <= '0;
      ld_rd  <= '0;
    end else if (state == S_DECODE) begin
      ld_f3  <= f3;
      ld_off <= ld_addr[1:0];
      ld_rd  <= rd;
    end
  end
endmodule

// File: tb/tb_rv32_core.sv
// Directed self-checking bench for rv32_core: debug port, ALU, loads/stores, branches, jumps, reset.
module tb_rv32_core;
  localparam logic [6:0] T_OP = 7'b0110011, T_OPI = 7'b0010011, T_LD = 7'b0000011;
  localparam logic [6:0] T_ST = 7'b0100011, T_BR = 7'b1100011, T_JAL = 7'b1101111;
  localparam logic [6:0] T_JALR = 7'b1100111, T_LUI = 7'b0110111, T_AUIPC = 7'b0010111;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] da2, dwd2, drd2, ia2, iwd2, ird2;
  logic [3:0]  dwe2, iwe2;
  logic [31:0] prog [$];
  logic [31:0] v;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  rv32_core #(.BRAM_WORDS(4096)) dut (
    .CPU_CLK(clk), .CPU_RST(rst),
    .CPU_Debug_DataRAM_A2(da2), .CPU_Debug_DataRAM_WD2(dwd2),
    .CPU_Debug_DataRAM_WE2(dwe2), .CPU_Debug_DataRAM_RD2(drd2),
    .CPU_Debug_InstRAM_A2(ia2), .CPU_Debug_InstRAM_WD2(iwd2),
    .CPU_Debug_InstRAM_WE2(iwe2), .CPU_Debug_InstRAM_RD2(ird2)
  );

  function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, T_OP};
  endfunction
  function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] s_t(input logic [11:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], T_ST};
  endfunction
  function automatic logic [31:0] b_t(input logic [12:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], T_BR};
  endfunction
  function automatic logic [31:0] u_t(input logic [19:0] imm, input logic [4:0] rd,
      input logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] j_t(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, T_JAL};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic dwrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    da2 = a; dwd2 = d; dwe2 = we;
    tick(1);
    dwe2 = '0;
  endtask

  task automatic dread(input logic [31:0] a, output logic [31:0] d);
    da2 = a; dwe2 = '0;
    tick(1);
    d = drd2;
  endtask

  task automatic iwrite(input logic [31:0] a, input logic [31:0] d);
    ia2 = a; iwd2 = d; iwe2 = 4'hF;
    tick(1);
    iwe2 = '0;
  endtask

  task automatic iread(input logic [31:0] a, output logic [31:0] d);
    ia2 = a; iwe2 = '0;
    tick(1);
    d = ird2;
  endtask

  task automatic load_prog();
    for (int i = 0; i < prog.size(); i++) iwrite(32'(4 * i), prog[i]);
  endtask

  initial begin
    rst = 1'b1;
    da2 = '0; dwd2 = '0; dwe2 = '0; ia2 = '0; iwd2 = '0; iwe2 = '0;
    tick(2);
    check("rst_data_rd2", drd2, 32'h0);
    check("rst_inst_rd2", ird2, 32'h0);

    // Debug port behaviour with the core parked on a self-loop
    iwrite(32'h0, j_t(21'd0, 5'd0));
    rst = 1'b0;
    tick(1);
    dwrite(32'h10, 32'hDEADBEEF, 4'b1111);
    dread(32'h10, v);  check("dbg_word", v, 32'hDEADBEEF);
    dwrite(32'h10, 32'h000000AA, 4'b0001);
    dread(32'h10, v);  check("dbg_byte0", v, 32'hDEADBEAA);
    dwrite(32'h10, 32'h12345678, 4'b1111);
    check("dbg_read_first", drd2, 32'hDEADBEAA);
    dread(32'h10, v);  check("dbg_after_write", v, 32'h12345678);
    iread(32'h4000, v); check("inst_wrap", v, 32'h0000006F);

    // Straight-line ALU program and store timing
    rst = 1'b1; tick(1);
    prog.delete();
    prog.push_back(i_t(12'd5, 5'd0, 3'b000, 5'd1, T_OPI));        // 00 addi x1,x0,5
    prog.push_back(i_t(12'd7, 5'd1, 3'b000, 5'd2, T_OPI));        // 04 addi x2,x1,7
    prog.push_back(s_t(12'd0, 5'd2, 5'd0, 3'b010));               // 08 sw x2,0
    prog.push_back(i_t(12'd5, 5'd0, 3'b000, 5'd0, T_OPI));        // 0C addi x0,x0,5
    prog.push_back(s_t(12'd4, 5'd0, 5'd0, 3'b010));               // 10 sw x0,4
    prog.push_back(u_t(20'h12345, 5'd3, T_LUI));                  // 14 lui x3
    prog.push_back(s_t(12'd8, 5'd3, 5'd0, 3'b010));               // 18 sw x3,8
    prog.push_back(r_t(7'h20, 5'd2, 5'd1, 3'b000, 5'd4));         // 1C sub x4,x1,x2
    prog.push_back(i_t(12'h401, 5'd4, 3'b101, 5'd5, T_OPI));      // 20 srai x5,x4,1
    prog.push_back(s_t(12'd12, 5'd5, 5'd0, 3'b010));              // 24 sw x5,12
    prog.push_back(r_t(7'h00, 5'd4, 5'd1, 3'b011, 5'd6));         // 28 sltu x6,x1,x4
    prog.push_back(r_t(7'h00, 5'd1, 5'd4, 3'b010, 5'd7));         // 2C slt x7,x4,x1
    prog.push_back(r_t(7'h00, 5'd7, 5'd6, 3'b000, 5'd8));         // 30 add x8,x6,x7
    prog.push_back(s_t(12'd16, 5'd8, 5'd0, 3'b010));              // 34 sw x8,16
    prog.push_back(u_t(20'h00001, 5'd9, T_AUIPC));                // 38 auipc x9,1
    prog.push_back(s_t(12'd20, 5'd9, 5'd0, 3'b010));              // 3C sw x9,20
    prog.push_back(j_t(21'd0, 5'd0));                             // 40 halt
    load_prog();
    dwrite(32'h0, 32'h0, 4'hF);
    dwrite(32'h4, 32'hFFFFFFFF, 4'hF);
    da2 = 32'h0;
    rst = 1'b0;
    tick(6); check("alu_sw_before_commit", drd2, 32'h0);
    tick(1); check("alu_sw_commit", drd2, 32'h0000000C);
    tick(60);
    dread(32'h04, v); check("alu_x0_discard", v, 32'h0);
    dread(32'h08, v); check("alu_lui", v, 32'h12345000);
    dread(32'h0C, v); check("alu_sub_srai", v, 32'hFFFFFFFC);
    dread(32'h10, v); check("alu_slt_sltu", v, 32'h2);
    dread(32'h14, v); check("alu_auipc", v, 32'h00001038);

    // Loads with sign/zero extension, sub-word stores, misaligned word/half
    rst = 1'b1; tick(1);
    prog.delete();
    prog.push_back(i_t(12'd0, 5'd0, 3'b000, 5'd1, T_LD));         // lb  x1,0
    prog.push_back(s_t(12'd4, 5'd1, 5'd0, 3'b010));
    prog.push_back(i_t(12'd0, 5'd0, 3'b100, 5'd2, T_LD));         // lbu x2,0
    prog.push_back(s_t(12'd8, 5'd2, 5'd0, 3'b010));
    prog.push_back(i_t(12'd0, 5'd0, 3'b001, 5'd3, T_LD));         // lh  x3,0
    prog.push_back(s_t(12'd12, 5'd3, 5'd0, 3'b010));
    prog.push_back(i_t(12'd0, 5'd0, 3'b101, 5'd4, T_LD));         // lhu x4,0
    prog.push_back(s_t(12'd16, 5'd4, 5'd0, 3'b010));
    prog.push_back(i_t(12'd1, 5'd0, 3'b000, 5'd5, T_LD));         // lb  x5,1
    prog.push_back(i_t(12'd1, 5'd0, 3'b100, 5'd6, T_LD));         // lbu x6,1
    prog.push_back(s_t(12'd21, 5'd6, 5'd0, 3'b000));              // sb x6,21
    prog.push_back(s_t(12'd26, 5'd1, 5'd0, 3'b001));              // sh x1,26
    prog.push_back(i_t(12'd3, 5'd0, 3'b010, 5'd7, T_LD));         // lw  x7,3
    prog.push_back(s_t(12'd28, 5'd7, 5'd0, 3'b010));
    prog.push_back(i_t(12'd3, 5'd0, 3'b001, 5'd8, T_LD));         // lh  x8,3
    prog.push_back(s_t(12'd32, 5'd8, 5'd0, 3'b010));
    prog.push_back(s_t(12'd36, 5'd5, 5'd0, 3'b010));
    prog.push_back(j_t(21'd0, 5'd0));
    load_prog();
    dwrite(32'h00, 32'h000080FF, 4'hF);
    for (int w = 1; w < 10; w++) dwrite(32'(4 * w), (w == 8) ? 32'hFFFFFFFF : 32'h0, 4'hF);
    rst = 1'b0;
    tick(100);
    dread(32'h04, v); check("ld_lb", v, 32'hFFFFFFFF);
    dread(32'h08, v); check("ld_lbu", v, 32'h000000FF);
    dread(32'h0C, v); check("ld_lh", v, 32'hFFFF80FF);
    dread(32'h10, v); check("ld_lhu", v, 32'h000080FF);
    dread(32'h14, v); check("st_sb_lane1", v, 32'h00008000);
    dread(32'h18, v); check("st_sh_upper", v, 32'hFFFF0000);
    dread(32'h1C, v); check("ld_lw_misaligned", v, 32'h000080FF);
    dread(32'h20, v); check("ld_lh_misaligned", v, 32'h0);
    dread(32'h24, v); check("ld_lb_byte1", v, 32'hFFFFFF80);

    // Branch loop and signed/unsigned comparisons
    rst = 1'b1; tick(1);
    prog.delete();
    prog.push_back(i_t(12'd10, 5'd0, 3'b000, 5'd1, T_OPI));       // 00 addi x1,x0,10
    prog.push_back(i_t(12'd0, 5'd0, 3'b000, 5'd2, T_OPI));        // 04 addi x2,x0,0
    prog.push_back(i_t(12'd1, 5'd2, 3'b000, 5'd2, T_OPI));        // 08 addi x2,x2,1
    prog.push_back(i_t(12'hFFF, 5'd1, 3'b000, 5'd1, T_OPI));      // 0C addi x1,x1,-1
    prog.push_back(b_t(13'h1FF8, 5'd0, 5'd1, 3'b001));            // 10 bne x1,x0,-8
    prog.push_back(s_t(12'd32, 5'd1, 5'd0, 3'b010));              // 14 sw x1,32
    prog.push_back(s_t(12'd36, 5'd2, 5'd0, 3'b010));              // 18 sw x2,36
    prog.push_back(i_t(12'hFFF, 5'd0, 3'b000, 5'd3, T_OPI));      // 1C addi x3,x0,-1
    prog.push_back(b_t(13'd12, 5'd1, 5'd3, 3'b110));              // 20 bltu x3,x1 (not taken)
    prog.push_back(b_t(13'd12, 5'd1, 5'd3, 3'b100));              // 24 blt x3,x1 -> 30
    prog.push_back(s_t(12'd40, 5'd3, 5'd0, 3'b010));              // 28 marker
    prog.push_back(s_t(12'd40, 5'd3, 5'd0, 3'b010));              // 2C marker
    prog.push_back(b_t(13'd8, 5'd3, 5'd1, 3'b101));               // 30 bge x1,x3 -> 38
    prog.push_back(s_t(12'd40, 5'd3, 5'd0, 3'b010));              // 34 marker
    prog.push_back(j_t(21'd0, 5'd0));                             // 38 halt
    load_prog();
    dwrite(32'h20, 32'hFFFFFFFF, 4'hF);
    dwrite(32'h24, 32'h0, 4'hF);
    dwrite(32'h28, 32'h00000055, 4'hF);
    rst = 1'b0;
    tick(200);
    dread(32'h20, v); check("br_loop_x1", v, 32'h0);
    dread(32'h24, v); check("br_loop_count", v, 32'd10);
    dread(32'h28, v); check("br_compare_path", v, 32'h00000055);

    // JAL / JALR targets and link values
    rst = 1'b1; tick(1);
    prog.delete();
    prog.push_back(j_t(21'd32, 5'd0));                            // 00 jal x0,+32
    prog.push_back(i_t(12'd1, 5'd0, 3'b000, 5'd3, T_OPI));        // 04 skipped
    for (int i = 0; i < 6; i++) prog.push_back(32'h0);            // 08..1C
    prog.push_back(j_t(21'd8, 5'd1));                             // 20 jal x1,+8
    prog.push_back(i_t(12'd1, 5'd0, 3'b000, 5'd3, T_OPI));        // 24 skipped
    prog.push_back(b_t(13'd12, 5'd0, 5'd2, 3'b001));              // 28 bne x2,x0,+12
    prog.push_back(s_t(12'd40, 5'd1, 5'd0, 3'b010));              // 2C sw x1,40
    prog.push_back(i_t(12'd5, 5'd1, 3'b000, 5'd2, T_JALR));       // 30 jalr x2,x1,5
    prog.push_back(s_t(12'd44, 5'd2, 5'd0, 3'b010));              // 34 sw x2,44
    prog.push_back(s_t(12'd48, 5'd3, 5'd0, 3'b010));              // 38 sw x3,48
    prog.push_back(j_t(21'd0, 5'd0));                             // 3C halt
    load_prog();
    dwrite(32'h28, 32'h0, 4'hF);
    dwrite(32'h2C, 32'h0, 4'hF);
    dwrite(32'h30, 32'hFFFFFFFF, 4'hF);
    rst = 1'b0;
    tick(100);
    dread(32'h28, v); check("jal_link", v, 32'h00000024);
    dread(32'h2C, v); check("jalr_link", v, 32'h00000034);
    dread(32'h30, v); check("jump_skipped", v, 32'h0);

    // Reset asserted mid-loop: memory kept, execution restarts from a clean state
    rst = 1'b1; tick(1);
    prog.delete();
    prog.push_back(i_t(12'd1, 5'd1, 3'b000, 5'd1, T_OPI));        // 00 addi x1,x1,1
    prog.push_back(s_t(12'd48, 5'd1, 5'd0, 3'b010));              // 04 sw x1,48
    prog.push_back(j_t(21'h1FFFF8, 5'd0));                        // 08 jal x0,-8
    load_prog();
    dwrite(32'h30, 32'h0, 4'hF);
    da2 = 32'h30;
    rst = 1'b0;
    tick(27);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1); check("rst_mem_retained", drd2, 32'd4);
    tick(4); check("rst_restart_first", drd2, 32'd1);
    tick(6); check("rst_restart_second", drd2, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
